// File: rtl/incdec_pkg.sv
// Shared op encoding for incdec_reg and the control-unit decoder.
package incdec_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_HOLD = 2'b00;
    localparam op_t OP_INC  = 2'b01;
    localparam op_t OP_DEC  = 2'b10;
    localparam op_t OP_LOAD = 2'b11;

endpackage

// File: rtl/incdec_core.sv
// Combinational WIDTH+1-bit add/subtract of a step, reporting carry/borrow.
// With INCDEC_SAT_EN defined, overflowing results clamp to max/zero instead of wrapping.
module incdec_core #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] s,
    input  logic             dec,
    output logic [WIDTH-1:0] nxt,
    output logic             flow
);

    logic [WIDTH:0] wide;

    always_comb begin
        if (dec) begin
            wide = {1'b0, q_in} - {1'b0, s};
        end else begin
            wide = {1'b0, q_in} + {1'b0, s};
        end
        flow = wide[WIDTH];
`ifdef INCDEC_SAT_EN
        if (wide[WIDTH]) begin
            nxt = dec ? '0 : '1;
        end else begin
            nxt = wide[WIDTH-1:0];
        end
`else
        nxt = wide[WIDTH-1:0];
`endif
    end

endmodule

// File: rtl/incdec_reg.sv
// Register with step increment/decrement/load and registered carry, borrow and zero flags.
// Saturating arithmetic is selected by defining INCDEC_SAT_EN (default: wrap-around).
module incdec_reg
    import incdec_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               STEP_W    = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  op_t               op,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  q,
    output logic              cout,
    output logic              bout,
    output logic              zero
);

    logic [WIDTH-1:0] val_q, val_d;
    logic             cout_q, cout_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] core_nxt;
    logic             core_flow;

    // A zero step is promoted to one so INC/DEC always move.
    assign s = (step == '0) ? WIDTH'(1) : WIDTH'(step);

    incdec_core #(.WIDTH(WIDTH)) u_core (
        .q_in (val_q),
        .s    (s),
        .dec  (op == OP_DEC),
        .nxt  (core_nxt),
        .flow (core_flow)
    );

    always_comb begin
        val_d  = val_q;
        cout_d = 1'b0;
        bout_d = 1'b0;
        if (en) begin
            case (op)
                OP_INC: begin
                    val_d  = core_nxt;
                    cout_d = core_flow;
                end
                OP_DEC: begin
                    val_d  = core_nxt;
                    bout_d = core_flow;
                end
                OP_LOAD: val_d = din;
                default: val_d = val_q;
            endcase
        end
        zero_d = (val_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q  <= RESET_VAL;
            cout_q <= 1'b0;
            bout_q <= 1'b0;
            zero_q <= (RESET_VAL == '0);
        end else begin
            val_q  <= val_d;
            cout_q <= cout_d;
            bout_q <= bout_d;
            zero_q <= zero_d;
        end
    end

    assign q    = val_q;
    assign cout = cout_q;
    assign bout = bout_q;
    assign zero = zero_q;

endmodule

// File: doc/incdec_reg.md
# incdec_reg

Parametrised register with built-in increment/decrement/load, successor to the fixed 8-bit inc8/dec8 combinational pair. Holds a WIDTH-bit value and, each enabled cycle, adds or subtracts a programmable step, loads a new value, or holds. Registered carry, borrow and zero flags are produced for the control unit. It serves as the program counter and stack pointer register, and as a general loop counter, in the datapath.

## Interface
- WIDTH, 8: register width in bits, ≥2.
- STEP_W, 1: width of the step input, 1 ≤ STEP_W ≤ WIDTH.
- RESET_VAL, 0: value of q after reset, WIDTH bits.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  operation enable; when 0 the register and flags hold.
- op  in  2  operation: 00 HOLD, 01 INC, 10 DEC, 11 LOAD.
- step  in  STEP_W  unsigned step for INC/DEC; step=0 behaves as step=1.
- din  in  WIDTH  load value for LOAD.
- q  out  WIDTH  registered value.
- cout  out  1  registered; 1 for one cycle after an INC that overflowed.
- bout  out  1  registered; 1 for one cycle after a DEC that underflowed.
- zero  out  1  registered; q == 0, always tracks q.

## Operation
- Effective step: s = (step == 0) ? 1 : step, zero-extended to WIDTH+1 bits.
- INC: sum = {1'b0,q} + s; overflow when sum[WIDTH] = 1.
- DEC: diff = {1'b0,q} − s; underflow when diff[WIDTH] = 1, i.e. s > q.
- Default wrap behaviour: q ← low WIDTH bits of sum/diff (modulo 2^WIDTH).
- LOAD: q ← din. cout = bout = 0.
- HOLD, or en=0: q holds. cout = bout = 0 on the next cycle, so the flags are pulses.
- The cout/bout values seen after an edge describe only the operation performed at that edge.
- zero is recomputed from the next-state value and registered together with q. It is never a stale value.
- Priority: rst > en=0 > op.

## Timing
- Latency: one cycle. The operation sampled at edge N is visible on q and the flags after edge N.
- Back-to-back operations are allowed every cycle with no bubble.
- Reset values: q = RESET_VAL, cout = 0, bout = 0, zero = (RESET_VAL == 0).
- rst asserted together with any op: reset wins and the op is discarded.
- Boundary, wrap mode:
  - q = 2^WIDTH−1, INC by 1 gives q = 0, cout = 1, zero = 1.
  - q = 0, DEC by 1 gives q = 2^WIDTH−1, bout = 1.
- Boundary, multi-step: INC by s with q+s > max wraps modulo, with cout = 1 for a single cycle.
- Combinational paths: there is no path from any input to any output. All outputs are flops.

## Configuration
- Macro INCDEC_SAT_EN.
  - Defined: saturating arithmetic. An INC that overflows gives q = 2^WIDTH−1. A DEC that underflows gives q = 0. cout/bout still pulse on the saturating operation. A further INC at max (or DEC at 0) pulses cout (or bout) again with q unchanged.
  - Undefined: wrap-around as described in Operation. The saturation logic is absent from the netlist.

## Structure
- Shared package incdec_pkg holds:
  - op encoding constants OP_HOLD, OP_INC, OP_DEC, OP_LOAD;
  - a 2-bit op typedef used by incdec_reg and the control-unit decoder.
- Sub-module incdec_core: purely combinational.
  - Inputs: q, s, direction.
  - Outputs: next value and the overflow/underflow bit, WIDTH+1-bit arithmetic.
  - Saturation clamp is placed in incdec_core under INCDEC_SAT_EN.
- incdec_reg holds the flops, op decode and enable/reset priority.

## Test plan
Benches run at WIDTH=8, STEP_W=4 unless stated otherwise.
- Reset with RESET_VAL=8'h10 → q=8'h10, cout=0, bout=0, zero=0. Then LOAD din=0 → q=0, zero=1.
- LOAD 8'hFE, INC step=1 twice → q=8'hFF with cout=0, then q=8'h00 with cout=1, zero=1. Then HOLD → cout=0, q=0.
- LOAD 8'h03, DEC step=5 → wrap gives q=8'hFE, bout=1. With INCDEC_SAT_EN defined → q=8'h00, bout=1, zero=1.
- LOAD 8'hF0, INC step=0 → q=8'hF1 (step treated as 1). Then INC step=15 → q=8'h00, cout=1 (wrap) / q=8'hFF, cout=1 (SAT).
- en=0 with op=INC for 3 cycles → q and zero unchanged, cout=0. Then rst asserted in the same cycle as LOAD 8'h55 → q=RESET_VAL, not 8'h55.
- Random op/step/din sequence over 1000 cycles, checked every cycle against a reference model, with WIDTH=16, STEP_W=16, in both macro settings.
